memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/common_types_pkg.sv | 4 +
 rtl/memory_arbiter.sv | 73 +++++++
 tb/tb_memory_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/common_types_pkg.sv
// common_types_pkg: shared enums for the datapath blocks.
package common_types_pkg;
  typedef enum logic [1:0] {IDLE, IACCESS, DACCESS} mem_arb_state_t;
endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port RAM between the CPU instruction and data ports,
// alternating grants under contention and only reporting hits for requests that are unchanged.
module memory_arbiter
  import common_types_pkg::*;
#(
  parameter logic LAST_GRANT_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dren,
  input  logic [3:0]  dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ram_ren,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);
  mem_arb_state_t state, next;
  logic        last;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wen_q;
  logic        wr_q;
  logic        i_pend, d_pend, d_wr, ihit, dhit;
  assign i_pend = iren;
  assign d_wr   = |dwen;
  assign d_pend = dren | d_wr;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state   <= IDLE;
      last    <= LAST_GRANT_INIT;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wen_q   <= '0;
      wdata_q <= '0;
    end else begin
      state <= next;
      if (state == IDLE && next != IDLE) begin
        last    <= next == DACCESS;
        addr_q  <= next == DACCESS ? daddr : iaddr;
        wr_q    <= next == DACCESS && d_wr;
        wen_q   <= dwen;
        wdata_q <= dstore;
      end
    end
  // last=0 means the instruction port was served most recently, so data wins a tie
  always_comb begin
    next = state;
    if (state == IDLE)
      next = d_pend && (!i_pend || !last) ? DACCESS : i_pend ? IACCESS : IDLE;
    else if (ram_ready)
      next = IDLE;
  end
  assign ram_addr  = {addr_q[31:2], 2'b00};
  assign ram_wdata = wdata_q;
  assign ram_ren   = state == IACCESS || (state == DACCESS && !wr_q);
  assign ram_wen   = state == DACCESS && wr_q ? wen_q : 4'b0000;
  assign ihit = state == IACCESS && ram_ready && iren && iaddr == addr_q;
  assign dhit = state == DACCESS && ram_ready && d_pend && daddr == addr_q && d_wr == wr_q &&
                (!wr_q || (dwen == wen_q && dstore == wdata_q));
  assign iwait = !ihit;
  assign iload = ihit ? ram_rdata : '0;
  assign dwait = d_pend && !dhit;
  assign dload = dhit && !wr_q ? ram_rdata : '0;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios for memory_arbiter with hand-computed expectations.
module tb_memory_arbiter;
  logic        clk, nrst;
  logic        iren, dren, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ram_rdata;
  logic [3:0]  dwen;
  logic [31:0] iload, dload, ram_addr, ram_wdata;
  logic        iwait, dwait, ram_ren;
  logic [3:0]  ram_wen;
  int tests = 0;
  int fails = 0;

  memory_arbiter #(.LAST_GRANT_INIT(1'b0)) dut (
    .clk(clk), .nrst(nrst),
    .iren(iren), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to the next falling edge, apply inputs, let combinational outputs settle
  task automatic cyc(input logic ie, input logic [31:0] ia, input logic de, input logic [3:0] dw,
                     input logic [31:0] da, input logic [31:0] ds, input logic rdy, input logic [31:0] rd);
    @(negedge clk);
    iren = ie; iaddr = ia; dren = de; dwen = dw; daddr = da; dstore = ds;
    ram_ready = rdy; ram_rdata = rd;
    #1;
  endtask

  task automatic test_reset;
    nrst = 1'b0; iren = 0; iaddr = 0; dren = 0; dwen = 0; daddr = 0; dstore = 0;
    ram_ready = 0; ram_rdata = 0;
    #1;
    tests++; if (ram_ren !== 1'b0) begin fails++; $display("FAIL reset_ren: got %h exp 0", ram_ren); end
    tests++; if (ram_wen !== 4'h0) begin fails++; $display("FAIL reset_wen: got %h exp 0", ram_wen); end
    tests++; if (ram_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h exp 0", ram_addr); end
    tests++; if (ram_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h exp 0", ram_wdata); end
    tests++; if (iwait !== 1'b1 || iload !== 32'h0) begin fails++; $display("FAIL reset_i: got iwait=%b iload=%h exp 1/0", iwait, iload); end
    tests++; if (dload !== 32'h0 || dwait !== 1'b0) begin fails++; $display("FAIL reset_d: got dload=%h dwait=%b exp 0/0", dload, dwait); end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_instr;
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    tests++; if (ram_ren !== 1'b0 || iwait !== 1'b1) begin fails++; $display("FAIL instr_idle: got ren=%b iwait=%b exp 0/1", ram_ren, iwait); end
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h100, 0, 0, 0, 0, k == 2, k == 2 ? 32'h13 : 32'hBAD);
      tests++; if (ram_ren !== 1'b1 || ram_addr !== 32'h100) begin fails++; $display("FAIL instr_acc%0d: got ren=%b addr=%h exp 1/100", k, ram_ren, ram_addr); end
      tests++; if (iwait !== (k != 2) || iload !== (k == 2 ? 32'h13 : 32'h0)) begin fails++; $display("FAIL instr_hit%0d: got iwait=%b iload=%h", k, iwait, iload); end
    end
    cyc(0, 32'h100, 0, 0, 0, 0, 0, 0);
    tests++; if (ram_ren !== 1'b0 || ram_addr !== 32'h100) begin fails++; $display("FAIL instr_hold: got ren=%b addr=%h exp 0/100", ram_ren, ram_addr); end
    tests++; if (iwait !== 1'b1 || iload !== 32'h0) begin fails++; $display("FAIL instr_after: got iwait=%b iload=%h exp 1/0", iwait, iload); end
  endtask

  task automatic test_contention;
    cyc(1, 32'h400, 1, 0, 32'h204, 0, 0, 0);
    tests++; if (iwait !== 1'b1 || dwait !== 1'b1) begin fails++; $display("FAIL cont_idle: got iwait=%b dwait=%b exp 1/1", iwait, dwait); end
    cyc(1, 32'h400, 1, 0, 32'h204, 0, 1, 32'hDEAD0001);
    tests++; if (ram_addr !== 32'h204 || ram_ren !== 1'b1) begin fails++; $display("FAIL cont_dfirst: got addr=%h ren=%b exp 204/1", ram_addr, ram_ren); end
    tests++; if (dwait !== 1'b0 || dload !== 32'hDEAD0001 || iwait !== 1'b1) begin fails++; $display("FAIL cont_dhit: got dwait=%b dload=%h iwait=%b", dwait, dload, iwait); end
    cyc(1, 32'h400, 0, 0, 0, 0, 0, 0);
    tests++; if (ram_ren !== 1'b0) begin fails++; $display("FAIL cont_gap: got ren=%b exp 0", ram_ren); end
    cyc(1, 32'h400, 0, 0, 0, 0, 1, 32'h55);
    tests++; if (ram_addr !== 32'h400 || iwait !== 1'b0 || iload !== 32'h55) begin fails++; $display("FAIL cont_ihit: got addr=%h iwait=%b iload=%h exp 400/0/55", ram_addr, iwait, iload); end
  endtask

  task automatic test_alternate;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 32'h500, 1, 0, 32'h600, 0, 0, 0);
      tests++; if (ram_ren !== 1'b0) begin fails++; $display("FAIL alt_idle%0d: got ren=%b exp 0", k, ram_ren); end
      cyc(1, 32'h500, 1, 0, 32'h600, 0, 1, 32'(k));
      tests++; if (ram_addr !== (k % 2 == 0 ? 32'h600 : 32'h500)) begin fails++; $display("FAIL alt_grant%0d: got addr=%h exp %h", k, ram_addr, k % 2 == 0 ? 32'h600 : 32'h500); end
      tests++; if (dwait !== (k % 2 == 1) || iwait !== (k % 2 == 0)) begin fails++; $display("FAIL alt_hit%0d: got dwait=%b iwait=%b", k, dwait, iwait); end
    end
  endtask

  task automatic test_write;
    cyc(0, 0, 1, 4'b0100, 32'h302, 32'h00AB0000, 0, 0);
    tests++; if (dwait !== 1'b1 || ram_wen !== 4'h0) begin fails++; $display("FAIL wr_idle: got dwait=%b wen=%h exp 1/0", dwait, ram_wen); end
    cyc(0, 0, 1, 4'b0100, 32'h302, 32'h00AB0000, 0, 0);
    tests++; if (ram_wen !== 4'b0100 || ram_ren !== 1'b0) begin fails++; $display("FAIL wr_strobe: got wen=%b ren=%b exp 0100/0", ram_wen, ram_ren); end
    tests++; if (ram_addr !== 32'h300 || ram_wdata !== 32'h00AB0000) begin fails++; $display("FAIL wr_bus: got addr=%h wdata=%h exp 300/00ab0000", ram_addr, ram_wdata); end
    tests++; if (dwait !== 1'b1) begin fails++; $display("FAIL wr_wait: got dwait=%b exp 1", dwait); end
    cyc(0, 0, 1, 4'b0100, 32'h302, 32'h00AB0000, 1, 32'hFFFFFFFF);
    tests++; if (dwait !== 1'b0 || dload !== 32'h0) begin fails++; $display("FAIL wr_done: got dwait=%b dload=%h exp 0/0", dwait, dload); end
  endtask

  task automatic test_write_change;
    cyc(0, 0, 0, 4'hF, 32'h10, 32'h1, 0, 0);
    cyc(0, 0, 0, 4'hF, 32'h10, 32'h2, 1, 0);
    tests++; if (dwait !== 1'b1 || ram_wdata !== 32'h1) begin fails++; $display("FAIL wchg_stale: got dwait=%b wdata=%h exp 1/1", dwait, ram_wdata); end
    cyc(0, 0, 0, 4'hF, 32'h10, 32'h2, 0, 0);
    cyc(0, 0, 0, 4'hF, 32'h10, 32'h2, 1, 0);
    tests++; if (dwait !== 1'b0 || ram_wdata !== 32'h2 || ram_wen !== 4'hF) begin fails++; $display("FAIL wchg_new: got dwait=%b wdata=%h wen=%h", dwait, ram_wdata, ram_wen); end
  endtask

  task automatic test_addr_change;
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h200, 0, 0, 0, 0, 1, 32'h77);
    tests++; if (ram_addr !== 32'h100 || iwait !== 1'b1 || iload !== 32'h0) begin fails++; $display("FAIL achg_stale: got addr=%h iwait=%b iload=%h exp 100/1/0", ram_addr, iwait, iload); end
    cyc(1, 32'h200, 0, 0, 0, 0, 0, 0);
    tests++; if (ram_ren !== 1'b0) begin fails++; $display("FAIL achg_idle: got ren=%b exp 0", ram_ren); end
    cyc(1, 32'h200, 0, 0, 0, 0, 1, 32'h88);
    tests++; if (ram_addr !== 32'h200 || iwait !== 1'b0 || iload !== 32'h88) begin fails++; $display("FAIL achg_new: got addr=%h iwait=%b iload=%h exp 200/0/88", ram_addr, iwait, iload); end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 1, 0, 32'h700, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h700, 0, 0, 0);
    tests++; if (ram_ren !== 1'b1 || ram_addr !== 32'h700) begin fails++; $display("FAIL rmid_acc: got ren=%b addr=%h exp 1/700", ram_ren, ram_addr); end
    #1 nrst = 1'b0;
    #1;
    tests++; if (ram_ren !== 1'b0 || ram_wen !== 4'h0 || ram_addr !== 32'h0) begin fails++; $display("FAIL rmid_strobe: got ren=%b wen=%h addr=%h exp 0/0/0", ram_ren, ram_wen, ram_addr); end
    tests++; if (iwait !== 1'b1 || dwait !== 1'b1) begin fails++; $display("FAIL rmid_wait: got iwait=%b dwait=%b exp 1/1", iwait, dwait); end
    @(negedge clk);
    nrst = 1'b1; ram_ready = 1'b1; ram_rdata = 32'h66;
    #1;
    tests++; if (ram_ren !== 1'b0 || dwait !== 1'b1 || dload !== 32'h0) begin fails++; $display("FAIL rmid_ignore: got ren=%b dwait=%b dload=%h exp 0/1/0", ram_ren, dwait, dload); end
    cyc(0, 0, 1, 0, 32'h700, 0, 1, 32'h99);
    tests++; if (ram_addr !== 32'h700 || dwait !== 1'b0 || dload !== 32'h99) begin fails++; $display("FAIL rmid_retry: got addr=%h dwait=%b dload=%h exp 700/0/99", ram_addr, dwait, dload); end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_instr;
    test_contention;
    test_alternate;
    test_write;
    test_write_change;
    test_addr_change;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
